// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
//
// Write-side controller for the branch target buffer. Resolved taken
// branches/jumps from EX are buffered in a small FIFO and drained into the
// BTB write port one entry at a time. Each write is a single-cycle burst with
// all four BTB strobes raised together. While fetch is using the BTB read
// side, writes are deferred so LRU reads are not disturbed. A starvation
// limit bounds how long a write can be held off.
// -----------------------------------------------------------------------------
module btb_update_ctrl #(
  parameter int DEPTH    = 4,  // FIFO entries, power of 2, >= 2
  parameter int MAX_WAIT = 8,  // deferred cycles before a write is forced, >= 1
  parameter int s_offset = 2   // BTB line offset bits
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ex_valid,
  input  logic                        ex_taken,
  input  logic [31:0]                 ex_pc,
  input  logic [31:0]                 ex_target,
  output logic                        ex_ready,
  input  logic                        fetch_busy,
  output logic [31:0]                 btb_addr_w,
  output logic [8*(2**s_offset)-1:0]  btb_wdata,
  output logic                        btb_load_tag,
  output logic                        btb_load_data,
  output logic                        btb_set_valid,
  output logic                        btb_set_lru,
  output logic [15:0]                 update_cnt
);

  localparam int WDATA_W = 8 * (2 ** s_offset);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [31:0]       pc_mem  [DEPTH];
  logic [31:0]       tgt_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [31:0]       head_pc;
  logic [31:0]       head_target;
  logic [WDATA_W-1:0] head_data;
  logic              write_strobe;

  // A full FIFO refuses entries; a pop in the same cycle does not help,
  // since readiness depends on the registered count alone.
  assign ex_ready   = (count < DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = ex_valid & ex_taken & ex_ready;
  assign pop        = (state == ST_WRITE);

  assign head_pc     = pc_mem[rd_ptr];
  assign head_target = tgt_mem[rd_ptr];

  // Fit the 32-bit target into the BTB data word (zero-extend when wider).
  generate
    if (WDATA_W > 32) begin : g_wdata_ext
      assign head_data = {{(WDATA_W - 32){1'b0}}, head_target};
    end else if (WDATA_W == 32) begin : g_wdata_eq
      assign head_data = head_target;
    end else begin : g_wdata_trunc
      assign head_data = head_target[WDATA_W-1:0];
    end
  endgenerate

  // Capture a pushed entry into the slot at the write pointer.
  // NOTE: the storage array has no reset; count gates every read of it, so
  // stale contents are never observable and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= ex_pc;
      tgt_mem[wr_ptr] <= ex_target;
    end
  end

  // Advance pointers and occupancy on push/pop; both on one edge keeps count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Count completed BTB writes; wraps at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update_cnt <= '0;
    end else if (pop) begin
      update_cnt <= update_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write scheduler FSM
  // ---------------------------------------------------------------------------

  // State and deferral-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Next-state logic: defer while fetch is busy, but never past MAX_WAIT.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (fetch_busy) begin
            state_next = ST_WAIT;
            wait_next  = WAIT_ONE;
          end else begin
            state_next = ST_WRITE;
          end
        end
      end
      ST_WAIT: begin
        if (!fetch_busy || (wait_cnt == MAX_WAIT_C)) begin
          state_next = ST_WRITE;
        end else begin
          wait_next = wait_cnt + WAIT_ONE;
        end
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
        wait_next  = '0;
      end
      default: begin
        state_next = ST_IDLE;
        wait_next  = '0;
      end
    endcase
  end

  // Outputs: strobes only in WRITE; address/data always present the head.
  always_comb begin
    write_strobe = (state == ST_WRITE);
    btb_addr_w   = '0;
    btb_wdata    = '0;
    if (!fifo_empty) begin
      btb_addr_w = head_pc;
      btb_wdata  = head_data;
    end
  end

  assign btb_load_tag  = write_strobe;
  assign btb_load_data = write_strobe;
  assign btb_set_valid = write_strobe;
  assign btb_set_lru   = write_strobe;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btb_update_ctrl
//
// Directed scenarios followed by a randomized run. A transaction-level model
// (a queue of pending branches plus a deferral counter) predicts every output
// each cycle; directed scenarios add explicit checks on write order/timing.
// -----------------------------------------------------------------------------
module tb_btb_update_ctrl;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int S_OFF    = 2;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_ready;
  logic        fetch_busy;
  logic [31:0] btb_addr_w;
  logic [31:0] btb_wdata;
  logic        btb_load_tag;
  logic        btb_load_data;
  logic        btb_set_valid;
  logic        btb_set_lru;
  logic [15:0] update_cnt;

  btb_update_ctrl #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT),
    .s_offset (S_OFF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_taken      (ex_taken),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_ready      (ex_ready),
    .fetch_busy    (fetch_busy),
    .btb_addr_w    (btb_addr_w),
    .btb_wdata     (btb_wdata),
    .btb_load_tag  (btb_load_tag),
    .btb_load_data (btb_load_data),
    .btb_set_valid (btb_set_valid),
    .btb_set_lru   (btb_set_lru),
    .update_cnt    (update_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // Reference model: pending branches in arrival order, whether this cycle is
  // a write, how many cycles the current write has been deferred, and the
  // number of writes completed.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m_q[$];
  bit          m_write = 0;
  int          m_defer = 0;
  logic [15:0] m_upd   = '0;

  // Observed writes, for order/timing checks in directed scenarios.
  logic [31:0] log_pc[$];
  logic [31:0] log_dat[$];
  int          log_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_write = 0;
    m_defer = 0;
    m_upd   = '0;
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_dat.delete();
    log_cyc.delete();
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_pc;
    logic [31:0] exp_dat;
    exp_pc  = '0;
    exp_dat = '0;
    if (m_q.size() != 0) begin
      exp_pc  = m_q[0].pc;
      exp_dat = m_q[0].tgt;
    end
    check("load_tag",   btb_load_tag,  m_write);
    check("load_data",  btb_load_data, m_write);
    check("set_valid",  btb_set_valid, m_write);
    check("set_lru",    btb_set_lru,   m_write);
    check("addr_w",     btb_addr_w,    exp_pc);
    check("wdata",      btb_wdata,     exp_dat);
    check("ex_ready",   ex_ready,      m_q.size() < DEPTH);
    check("update_cnt", update_cnt,    m_upd);
  endtask

  // Apply one clock edge to the model, using the pre-edge occupancy.
  task automatic model_advance(input logic v, input logic t, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic busy);
    int cnt;
    bit do_push;
    bit next_write;
    ent_t e;
    cnt        = m_q.size();
    do_push    = v && t && (cnt < DEPTH);
    next_write = 0;
    if (m_write) begin
      void'(m_q.pop_front());
      m_upd   = m_upd + 16'd1;
      m_defer = 0;
    end else if (m_defer > 0) begin
      if (!busy || m_defer == MAX_WAIT) begin
        next_write = 1;
        m_defer    = 0;
      end else begin
        m_defer++;
      end
    end else if (cnt > 0) begin
      if (!busy) next_write = 1;
      else       m_defer    = 1;
    end
    if (do_push) begin
      e.pc  = pc;
      e.tgt = tgt;
      m_q.push_back(e);
    end
    m_write = next_write;
  endtask

  // One cycle: drive inputs at the falling edge, compare, clock, return.
  task automatic step(input logic v, input logic t, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic busy);
    ex_valid   = v;
    ex_taken   = t;
    ex_pc      = pc;
    ex_target  = tgt;
    fetch_busy = busy;
    #1;
    compare_outputs();
    if (btb_load_tag === 1'b1) begin
      log_pc.push_back(btb_addr_w);
      log_dat.push_back(btb_wdata);
      log_cyc.push_back(cyc);
    end
    model_advance(v, t, pc, tgt, busy);
    @(negedge clk);
  endtask

  task automatic drain(input logic busy);
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_write) && n < 400) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, busy);
      n++;
    end
    check("drain_bounded", n < 400, 1'b1);
  endtask

  initial begin
    int s;
    int n;
    int busy_pct;
    logic [31:0] rpc;

    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int n;
    int busy_pct;

    // ---- Power-on reset ----
    rst        = 1'b0;
    ex_valid   = 1'b0;
    ex_taken   = 1'b0;
    ex_pc      = '0;
    ex_target  = '0;
    fetch_busy = 1'b0;
    model_reset();
    #2;
    check("por_strobe",  btb_load_tag, 1'b0);
    check("por_addr",    btb_addr_w,   32'h0);
    check("por_wdata",   btb_wdata,    32'h0);
    check("por_ready",   ex_ready,     1'b1);
    check("por_upd",     update_cnt,   16'h0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // ---- Reset asserted mid-WRITE with 3 entries queued ----
    step(1'b1, 1'b1, 32'h0000_0a00, 32'h0000_1a00, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0b00, 32'h0000_1b00, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0c00, 32'h0000_1c00, 1'b1);
    n = 0;
    while (!m_write && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      n++;
    end
    check("rst_reach_write", m_write, 1'b1);
    check("rst_pre_strobe",  btb_load_tag, 1'b1);
    ex_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_tag_drop",   btb_load_tag,  1'b0);
    check("rst_data_drop",  btb_load_data, 1'b0);
    check("rst_valid_drop", btb_set_valid, 1'b0);
    check("rst_lru_drop",   btb_set_lru,   1'b0);
    check("rst_addr_zero",  btb_addr_w,    32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_no_writes", log_pc.size(), 0);
    check("rst_ready",     ex_ready,      1'b1);
    check("rst_upd",       update_cnt,    16'h0);

    // ---- Not-taken resolutions are ignored ----
    clear_log();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h100 + 32'(i), 32'h200, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("nt_no_writes", log_pc.size(), 0);
    check("nt_ready",     ex_ready,      1'b1);
    check("nt_upd",       update_cnt,    16'h0);

    // ---- Single push latency ----
    clear_log();
    s = cyc;
    step(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0100, 1'b0);
    drain(1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lat_nwrites", log_pc.size(), 1);
    if (log_pc.size() >= 1) begin
      check("lat_addr",  log_pc[0],      32'h40);
      check("lat_data",  log_dat[0],     32'h100);
      check("lat_cycle", log_cyc[0] - s, 2);
    end
    check("lat_upd", update_cnt, 16'd1);

    // ---- Four back-to-back pushes, no contention ----
    clear_log();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 32'(i * 16), 32'h8000 + 32'(i), 1'b0);
    drain(1'b0);
    check("ord_nwrites", log_pc.size(), 4);
    if (log_pc.size() == 4) begin
      for (int i = 0; i < 4; i++) check("ord_pc", log_pc[i], 32'((i + 1) * 16));
      for (int i = 1; i < 4; i++) check("ord_gap", log_cyc[i] - log_cyc[i-1], 2);
    end
    check("ord_upd", update_cnt, 16'd5);

    // ---- Fetch busy: fill, overflow drop, starvation-forced writes ----
    clear_log();
    s = cyc;
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 32'h1000 * 32'(i), 32'h5000 + 32'(i), 1'b1);
    check("busy_full_ready", ex_ready, 1'b0);
    step(1'b1, 1'b1, 32'h0000_5000, 32'h0000_9999, 1'b1);
    drain(1'b1);
    check("busy_nwrites", log_pc.size(), 4);
    if (log_pc.size() == 4) begin
      check("busy_first_cycle", log_cyc[0] - s, 10);
      for (int i = 0; i < 4; i++) check("busy_pc", log_pc[i], 32'h1000 * 32'(i + 1));
    end
    check("busy_upd", update_cnt, 16'd9);

    // ---- Push and pop on the same edge with 3 queued ----
    clear_log();
    step(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0a01, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0a02, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0a03, 1'b1);
    n = 0;
    while (!m_write && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      n++;
    end
    check("pp_in_write", btb_load_tag, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0400, 32'h0000_0a04, 1'b0);
    check("pp_ready", ex_ready, 1'b1);
    drain(1'b0);
    check("pp_nwrites", log_pc.size(), 4);
    if (log_pc.size() == 4) begin
      check("pp_order0", log_pc[0], 32'h100);
      check("pp_order1", log_pc[1], 32'h200);
      check("pp_order2", log_pc[2], 32'h300);
      check("pp_order3", log_pc[3], 32'h400);
      check("pp_data3",  log_dat[3], 32'ha04);
    end
    check("pp_upd", update_cnt, 16'd13);

    // ---- Randomized traffic against the model ----
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       busy_pct = 20;
        1:       busy_pct = 80;
        2:       busy_pct = 100;
        default: busy_pct = 50;
      endcase
      for (int i = 0; i < 150; i++) begin
        step(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0),
             32'($urandom_range(0, 255)) << 2,
             $urandom(),
             1'($urandom_range(0, 99) < busy_pct));
      end
    end
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
